pattern_detector: RTL and testbench

PATTERN_DETECTOR -- requirements
Module: pattern_detector

---
 rtl/pattern_detector.sv | 104 ++++++++++
 tb/tb_pattern_detector.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_detector.sv
// pattern_detector: serial bit-stream matcher with per-bit compare mask,
// overlapping/non-overlapping match modes and a one-cycle hit pulse.
// Optional feature: define DETECT_HIT_CNT_EN to build the saturating hit
// counter behind o_hit_cnt; without it o_hit_cnt is tied to zero.
module pattern_detector #(
  parameter int PAT_W = 9,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             s_valid,
  input  logic             s_data,
  input  logic             i_cfg_load,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic [PAT_W-1:0] i_mask,
  input  logic             i_overlap,
  input  logic             i_clr_cnt,
  output logic             o_hit,
  output logic [CNT_W-1:0] o_hit_cnt
);

  // Fill counter only has to count up to PAT_W, then it saturates.
  localparam int                FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  history;
  logic [PAT_W-1:0]  history_next;
  logic [PAT_W-1:0]  pat_reg;
  logic [PAT_W-1:0]  mask_reg;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;
  logic              match;

  // Next history/fill and the match decision for the bit sampled this edge
  always_comb begin
    history_next = {s_data, history[PAT_W-1:1]};
    fill_next    = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
    match        = 1'b0;
    if (s_valid && !i_cfg_load && (fill_next == FILL_FULL)) begin
      match = (((history_next ^ pat_reg) & mask_reg) == '0);
    end
  end

  // Pattern and mask registers, captured on a configuration pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pat_reg  <= '0;
      mask_reg <= '1;
    end else if (i_cfg_load) begin
      pat_reg  <= i_pattern;
      mask_reg <= i_mask;
    end
  end

  // History shift and fill tracking; a configuration load restarts both
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      history <= '0;
      fill    <= '0;
    end else if (i_cfg_load) begin
      history <= '0;
      fill    <= '0;
    end else if (s_valid) begin
      history <= history_next;
      if (match && !i_overlap) begin
        fill <= '0;
      end else begin
        fill <= fill_next;
      end
    end
  end

  // Registered hit pulse, one cycle after the completing bit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hit <= 1'b0;
    end else begin
      o_hit <= match;
    end
  end

`ifdef DETECT_HIT_CNT_EN
  logic [CNT_W-1:0] hit_cnt;

  // Saturating hit counter; a clear in the same cycle as a hit wins
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hit_cnt <= '0;
    end else if (i_clr_cnt) begin
      hit_cnt <= '0;
    end else if (match && (hit_cnt != {CNT_W{1'b1}})) begin
      hit_cnt <= hit_cnt + CNT_W'(1);
    end
  end

  assign o_hit_cnt = hit_cnt;
`else
  // Counter not built: the clear input has nothing to act on.
  logic unused_clr_cnt;
  assign unused_clr_cnt = i_clr_cnt;
  assign o_hit_cnt      = '0;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// tb_pattern_detector: directed self-checking bench for pattern_detector.
// One instance uses PAT_W=9/CNT_W=16, a second uses PAT_W=3/CNT_W=2.
module tb_pattern_detector;

`ifdef DETECT_HIT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;

  logic        valid9, data9, cfg9, ovl9, clr9, hit9;
  logic [8:0]  pat9, mask9;
  logic [15:0] cnt9;

  logic        valid3, data3, cfg3, ovl3, clr3, hit3;
  logic [2:0]  pat3, mask3;
  logic [1:0]  cnt3;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt9 = 16'd0;
  logic [1:0]  exp_cnt3 = 2'd0;

  pattern_detector #(.PAT_W(9), .CNT_W(16)) dut9 (
    .i_clk(clk), .i_rst_n(rst_n), .s_valid(valid9), .s_data(data9),
    .i_cfg_load(cfg9), .i_pattern(pat9), .i_mask(mask9), .i_overlap(ovl9),
    .i_clr_cnt(clr9), .o_hit(hit9), .o_hit_cnt(cnt9)
  );

  pattern_detector #(.PAT_W(3), .CNT_W(2)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .s_valid(valid3), .s_data(data3),
    .i_cfg_load(cfg3), .i_pattern(pat3), .i_mask(mask3), .i_overlap(ovl3),
    .i_clr_cnt(clr3), .o_hit(hit3), .o_hit_cnt(cnt3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] model_cnt9(input logic [15:0] c, input logic hit, input logic clr);
    if (!CNT_EN || clr) return 16'd0;
    if (hit && (c != 16'hFFFF)) return c + 16'd1;
    return c;
  endfunction

  function automatic logic [1:0] model_cnt3(input logic [1:0] c, input logic hit, input logic clr);
    if (!CNT_EN || clr) return 2'd0;
    if (hit && (c != 2'd3)) return c + 2'd1;
    return c;
  endfunction

  task automatic send9(input logic d, input logic clr, output logic h, output logic [15:0] c);
    @(negedge clk);
    valid9 = 1'b1; data9 = d; clr9 = clr;
    @(posedge clk);
    #1;
    h = hit9; c = cnt9;
    valid9 = 1'b0; clr9 = 1'b0;
  endtask

  task automatic send3(input logic d, input logic clr, output logic h, output logic [1:0] c);
    @(negedge clk);
    valid3 = 1'b1; data3 = d; clr3 = clr;
    @(posedge clk);
    #1;
    h = hit3; c = cnt3;
    valid3 = 1'b0; clr3 = 1'b0;
  endtask

  task automatic load9(input logic [8:0] p, input logic [8:0] m, input logic dv, input logic d, output logic h);
    @(negedge clk);
    cfg9 = 1'b1; pat9 = p; mask9 = m; valid9 = dv; data9 = d;
    @(posedge clk);
    #1;
    h = hit9;
    cfg9 = 1'b0; valid9 = 1'b0;
  endtask

  task automatic load3(input logic [2:0] p, input logic [2:0] m, output logic h);
    @(negedge clk);
    cfg3 = 1'b1; pat3 = p; mask3 = m;
    @(posedge clk);
    #1;
    h = hit3;
    cfg3 = 1'b0;
  endtask

  task automatic idle9(input int n, output logic any_hit);
    any_hit = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      any_hit = any_hit | hit9;
    end
  endtask

  task automatic pulse_reset(output logic h9, output logic [15:0] c9, output logic h3, output logic [1:0] c3);
    #2 rst_n = 1'b0;
    #1;
    h9 = hit9; c9 = cnt9; h3 = hit3; c3 = cnt3;
    exp_cnt9 = 16'd0;
    exp_cnt3 = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (hit9 !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit9: got %b want 0", hit9); end
    checks++; if (cnt9 !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt9: got %0d want 0", cnt9); end
    checks++; if (hit3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit3: got %b want 0", hit3); end
    checks++; if (cnt3 !== 2'd0) begin errors++; $display("[TB] FAIL reset_cnt3: got %0d want 0", cnt3); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (hit9 !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_hit9: got %b want 0", hit9); end
  endtask

  task automatic test_fill();
    logic h, eh, h3r;
    logic [15:0] c;
    logic [1:0] c3r;
    ovl9 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      eh = (i == 8);
      send9(1'b0, 1'b0, h, c);
      exp_cnt9 = model_cnt9(exp_cnt9, eh, 1'b0);
      checks++; if (h !== eh) begin errors++; $display("[TB] FAIL fill_zero_bit%0d: got %b want %b", i, h, eh); end
    end
    checks++; if (c !== exp_cnt9) begin errors++; $display("[TB] FAIL fill_cnt: got %0d want %0d", c, exp_cnt9); end
    pulse_reset(h, c, h3r, c3r);
    checks++; if (h !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_hit: got %b want 0", h); end
    checks++; if (c !== 16'd0) begin errors++; $display("[TB] FAIL async_reset_cnt: got %0d want 0", c); end
    for (int i = 0; i < 8; i++) begin
      send9(1'b0, 1'b0, h, c);
      checks++; if (h !== 1'b0) begin errors++; $display("[TB] FAIL partial_bit%0d: got %b want 0", i, h); end
    end
    pulse_reset(h, c, h3r, c3r);
    for (int i = 0; i < 9; i++) begin
      eh = (i == 8);
      send9(1'b0, 1'b0, h, c);
      exp_cnt9 = model_cnt9(exp_cnt9, eh, 1'b0);
      checks++; if (h !== eh) begin errors++; $display("[TB] FAIL after_midreset_bit%0d: got %b want %b", i, h, eh); end
    end
    send9(1'b0, 1'b0, h, c);
    exp_cnt9 = model_cnt9(exp_cnt9, 1'b1, 1'b0);
    checks++; if (h !== 1'b1) begin errors++; $display("[TB] FAIL fill_overlap_rehit: got %b want 1", h); end
    checks++; if (c !== exp_cnt9) begin errors++; $display("[TB] FAIL fill_overlap_cnt: got %0d want %0d", c, exp_cnt9); end
  endtask

  task automatic test_basic();
    logic h, eh, any;
    logic [15:0] c;
    logic [8:0] seq;
    seq = 9'b101000111;
    load9(seq, 9'h1FF, 1'b0, 1'b0, h);
    ovl9 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      eh = (i == 8);
      send9(seq[i], 1'b0, h, c);
      exp_cnt9 = model_cnt9(exp_cnt9, eh, 1'b0);
      checks++; if (h !== eh) begin errors++; $display("[TB] FAIL basic_bit%0d: got %b want %b", i, h, eh); end
    end
    checks++; if (c !== exp_cnt9) begin errors++; $display("[TB] FAIL basic_cnt: got %0d want %0d", c, exp_cnt9); end
    idle9(1, any);
    checks++; if (any !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_after_hit: got %b want 0", any); end
  endtask

  task automatic test_gaps();
    logic h, eh, any;
    logic [15:0] c;
    logic [8:0] seq;
    seq = 9'b101000111;
    load9(seq, 9'h1FF, 1'b0, 1'b0, h);
    for (int i = 0; i < 9; i++) begin
      eh = (i == 8);
      send9(seq[i], 1'b0, h, c);
      exp_cnt9 = model_cnt9(exp_cnt9, eh, 1'b0);
      checks++; if (h !== eh) begin errors++; $display("[TB] FAIL gaps_bit%0d: got %b want %b", i, h, eh); end
      if (i < 8) begin
        idle9((i % 5) + 1, any);
        checks++; if (any !== 1'b0) begin errors++; $display("[TB] FAIL gaps_idle%0d: got %b want 0", i, any); end
      end
    end
    idle9(3, any);
    checks++; if (any !== 1'b0) begin errors++; $display("[TB] FAIL gaps_no_repeat: got %b want 0", any); end
    checks++; if (cnt9 !== exp_cnt9) begin errors++; $display("[TB] FAIL gaps_cnt: got %0d want %0d", cnt9, exp_cnt9); end
  endtask

  task automatic test_overlap();
    logic h, eh;
    logic [1:0] c;
    logic [4:0] stream, exp_ovl, exp_novl;
    stream   = 5'b10101;
    exp_ovl  = 5'b10100;
    exp_novl = 5'b00100;
    load3(3'b101, 3'b111, h);
    ovl3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      eh = exp_ovl[i];
      send3(stream[i], 1'b0, h, c);
      exp_cnt3 = model_cnt3(exp_cnt3, eh, 1'b0);
      checks++; if (h !== eh) begin errors++; $display("[TB] FAIL overlap1_bit%0d: got %b want %b", i, h, eh); end
    end
    load3(3'b101, 3'b111, h);
    ovl3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      eh = exp_novl[i];
      send3(stream[i], 1'b0, h, c);
      exp_cnt3 = model_cnt3(exp_cnt3, eh, 1'b0);
      checks++; if (h !== eh) begin errors++; $display("[TB] FAIL overlap0_bit%0d: got %b want %b", i, h, eh); end
    end
    checks++; if (c !== exp_cnt3) begin errors++; $display("[TB] FAIL overlap_cnt: got %0d want %0d", c, exp_cnt3); end
  endtask

  task automatic test_saturate();
    logic h, eh, clr, h9r;
    logic [1:0] c;
    logic [15:0] c9r;
    logic [12:0] hits, clrs;
    hits = 13'b1001111111100;
    clrs = 13'b0000010000000;
    pulse_reset(h9r, c9r, h, c);
    checks++; if (c !== 2'd0) begin errors++; $display("[TB] FAIL sat_reset_cnt3: got %0d want 0", c); end
    load3(3'b000, 3'b000, h);
    for (int i = 0; i < 13; i++) begin
      eh  = hits[i];
      clr = clrs[i];
      ovl3 = (i < 9);
      send3(i[0], clr, h, c);
      exp_cnt3 = model_cnt3(exp_cnt3, eh, clr);
      checks++; if (h !== eh) begin errors++; $display("[TB] FAIL sat_hit_bit%0d: got %b want %b", i, h, eh); end
      checks++; if (c !== exp_cnt3) begin errors++; $display("[TB] FAIL sat_cnt_bit%0d: got %0d want %0d", i, c, exp_cnt3); end
    end
  endtask

  task automatic test_mask();
    logic h, eh;
    logic [15:0] c;
    logic [9:0] s1, s2;
    s1 = 10'b0110110101;
    s2 = 10'b0000001010;
    ovl9 = 1'b1;
    load9(9'b000000101, 9'b000001111, 1'b0, 1'b0, h);
    for (int i = 0; i < 10; i++) begin
      eh = (i == 8);
      send9(s1[i], 1'b0, h, c);
      exp_cnt9 = model_cnt9(exp_cnt9, eh, 1'b0);
      checks++; if (h !== eh) begin errors++; $display("[TB] FAIL mask_bit%0d: got %b want %b", i, h, eh); end
    end
    load9(9'b000000101, 9'b000001111, 1'b1, 1'b1, h);
    checks++; if (h !== 1'b0) begin errors++; $display("[TB] FAIL load_discard_hit: got %b want 0", h); end
    for (int i = 0; i < 10; i++) begin
      eh = (i == 9);
      send9(s2[i], 1'b0, h, c);
      exp_cnt9 = model_cnt9(exp_cnt9, eh, 1'b0);
      checks++; if (h !== eh) begin errors++; $display("[TB] FAIL reload_bit%0d: got %b want %b", i, h, eh); end
    end
    checks++; if (c !== exp_cnt9) begin errors++; $display("[TB] FAIL mask_cnt: got %0d want %0d", c, exp_cnt9); end
  endtask

  initial begin
    valid9 = 1'b0; data9 = 1'b0; cfg9 = 1'b0; ovl9 = 1'b1; clr9 = 1'b0;
    pat9 = 9'd0; mask9 = 9'd0;
    valid3 = 1'b0; data3 = 1'b0; cfg3 = 1'b0; ovl3 = 1'b1; clr3 = 1'b0;
    pat3 = 3'd0; mask3 = 3'd0;
    test_reset();
    test_fill();
    test_basic();
    test_gaps();
    test_overlap();
    test_saturate();
    test_mask();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
